// File: rtl/depar_arb_pkg.sv
// depar_arb_pkg: shared state encoding, grant width and slice helper for the output arbiter
package depar_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    // Grant index is sized for the widest supported configuration (4 ports)
    localparam int C_MAX_PORTS   = 4;
    localparam int C_GRANT_WIDTH = $clog2(C_MAX_PORTS);

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/depar_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker starting the scan at prio_ptr
module rr_pick
    import depar_arb_pkg::*;
#(
    parameter int C_NUM_PORTS = 4
) (
    input  logic [C_NUM_PORTS-1:0]   req,
    input  logic [C_GRANT_WIDTH-1:0] prio_ptr,
    output logic [C_GRANT_WIDTH-1:0] grant,
    output logic                     found
);

    // scan from the farthest offset down so the port nearest prio_ptr wins
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(prio_ptr) + k) % C_NUM_PORTS]) begin
                grant = C_GRANT_WIDTH'((int'(prio_ptr) + k) % C_NUM_PORTS);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/depar_out_arbiter.sv
// depar_out_arbiter: packet-level round-robin merge of deparser AXIS outputs onto one egress stream
module depar_out_arbiter
    import depar_arb_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_PORTS        = 4,
    parameter int C_CNT_WIDTH        = 32
) (
    input  logic                                          axis_clk,
    input  logic                                          aresetn,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                        s_axis_tvalid,
    input  logic [C_NUM_PORTS-1:0]                        s_axis_tlast,
    output logic [C_NUM_PORTS-1:0]                        s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]                m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                          m_axis_tlast,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]            pkt_cnt
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;

    arb_state_t                 state, state_nxt;
    logic [C_GRANT_WIDTH-1:0]   grant, grant_nxt, prio_ptr, pick;
    logic                       found, out_free, accept, pkt_end;

    rr_pick #(.C_NUM_PORTS(C_NUM_PORTS)) u_pick (
        .req      (s_axis_tvalid),
        .prio_ptr (prio_ptr),
        .grant    (pick),
        .found    (found)
    );

    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign accept   = (state == LOCKED) && s_axis_tvalid[grant] && out_free;
    assign pkt_end  = accept && s_axis_tlast[grant];

    // next state, grant latch and ready steering toward the locked requester only
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        s_axis_tready = '0;
        if (state == IDLE) begin
            if (found) begin
                grant_nxt = pick;
                state_nxt = LOCKED;
            end
        end else begin
            s_axis_tready[grant] = out_free;
            if (pkt_end) state_nxt = IDLE;
        end
    end

    // state, grant and rotating priority; priority moves past the port that just finished
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            prio_ptr <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (pkt_end) prio_ptr <= C_GRANT_WIDTH'((int'(grant) + 1) % C_NUM_PORTS);
        end
    end

    // egress register: load on an accepted beat, drop valid once the beat is consumed
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            m_axis_tdata  <= s_axis_tdata[slice_lo(int'(grant), C_AXIS_DATA_WIDTH) +: C_AXIS_DATA_WIDTH];
            m_axis_tkeep  <= s_axis_tkeep[slice_lo(int'(grant), KW) +: KW];
            m_axis_tuser  <= s_axis_tuser[slice_lo(int'(grant), C_AXIS_TUSER_WIDTH) +: C_AXIS_TUSER_WIDTH];
            m_axis_tlast  <= s_axis_tlast[grant];
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // per-input packet counters, wrapping at the counter width
    always_ff @(posedge axis_clk) begin
        if (!aresetn) pkt_cnt <= '0;
        else if (pkt_end)
            pkt_cnt[slice_lo(int'(grant), C_CNT_WIDTH) +: C_CNT_WIDTH] <=
                pkt_cnt[slice_lo(int'(grant), C_CNT_WIDTH) +: C_CNT_WIDTH] + C_CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_depar_out_arbiter.sv
// tb_depar_out_arbiter: directed self-checking bench for the deparser output arbiter
module tb_depar_out_arbiter;
    import depar_arb_pkg::*;

    localparam int N = 4, DW = 32, UW = 8, KW = DW / 8, CW = 4;

    logic              axis_clk = 1'b0;
    logic              aresetn  = 1'b0;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N*UW-1:0]   s_axis_tuser;
    logic [N-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tlast, m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [N*CW-1:0]   pkt_cnt;

    int errors = 0, checks = 0, cyc = 0, t0;
    int pkts[N], nb[N], sent[N], pktno[N];
    logic [31:0] base[N];
    logic [N-1:0] hs;
    logic [31:0] log_data[64];
    logic [3:0]  log_keep[64];
    logic [7:0]  log_user[64];
    logic        log_last[64];
    int          log_cyc[64];
    int          nlog = 0;
    logic [45:0] prev_beat;
    logic        prev_stall = 1'b0;

    depar_out_arbiter #(
        .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_NUM_PORTS(N), .C_CNT_WIDTH(CW)
    ) dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .pkt_cnt(pkt_cnt)
    );

    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            logic [31:0] d;
            d = base[i] + 32'(pktno[i] * 256 + sent[i]);
            s_axis_tvalid[i]         = pkts[i] > 0;
            s_axis_tlast[i]          = sent[i] == nb[i] - 1;
            s_axis_tdata[i*DW +: DW] = d;
            s_axis_tkeep[i*KW +: KW] = s_axis_tlast[i] ? 4'h7 : 4'hF;
            s_axis_tuser[i*UW +: UW] = d[7:0] ^ 8'h5A;
        end
    endtask

    task automatic load(input int p, input int npk, input int nbeats, input logic [31:0] b);
        pkts[p] = npk; nb[p] = nbeats; sent[p] = 0; pktno[p] = 0; base[p] = b;
        drive_src();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            pkts[i] = 0; nb[i] = 1; sent[i] = 0; pktno[i] = 0; base[i] = '0;
        end
        drive_src();
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge axis_clk);
            #2;
        end
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while ((pkts[0] + pkts[1] + pkts[2] + pkts[3] > 0 || m_axis_tvalid) && n < maxc) begin
            @(posedge axis_clk);
            #2;
            n++;
        end
        chk("done_in_time", 64'(n < maxc), 64'(1));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        m_axis_tready = 1'b1;
        clear_src();
        repeat (2) @(posedge axis_clk);
        #2;
        aresetn = 1'b1;
        nlog = 0;
    endtask

    task automatic chk_beat(input int i, input int c, input logic [31:0] d, input logic [3:0] k,
                            input logic [7:0] u, input logic l);
        chk($sformatf("beat%0d_cyc", i), 64'(log_cyc[i]), 64'(c));
        chk($sformatf("beat%0d", i), {log_data[i], log_keep[i], log_user[i], log_last[i]}, {d, k, u, l});
    endtask

    // source model: advance each port after its handshake seen on the preceding edge
    initial forever begin
        @(negedge axis_clk);
        hs = s_axis_tvalid & s_axis_tready & {N{aresetn}};
        @(posedge axis_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (sent[i] == nb[i] - 1) begin
                    sent[i] = 0; pkts[i]--; pktno[i]++;
                end else sent[i]++;
            end
        end
        if (hs != '0) drive_src();
    end

    // egress monitor: log beats, check ready exclusivity and hold stability under stall
    always @(negedge axis_clk) begin
        logic [45:0] cur;
        cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid};
        if (aresetn) begin
            chk("rdy_onehot", 64'($onehot0(s_axis_tready)), 64'(1));
            if (prev_stall) chk("hold_stable", 64'(cur), 64'(prev_beat));
        end
        if (aresetn && m_axis_tvalid && m_axis_tready && nlog < 64) begin
            log_data[nlog] = m_axis_tdata; log_keep[nlog] = m_axis_tkeep;
            log_user[nlog] = m_axis_tuser; log_last[nlog] = m_axis_tlast;
            log_cyc[nlog]  = cyc;
            nlog++;
        end
        prev_stall = aresetn && m_axis_tvalid && !m_axis_tready;
        prev_beat  = cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_src();
        repeat (2) @(posedge axis_clk);
        #2;
        chk("rst_m", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid}, 64'(0));
        chk("rst_rdy", 64'(s_axis_tready), 64'(0));
        chk("rst_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        chk("rst_ptrs", {dut.grant, dut.prio_ptr}, 64'(0));
        aresetn = 1'b1;

        // single 3-beat packet on port 2
        do_reset(); t0 = cyc;
        load(2, 1, 3, 32'h2000_0000);
        wait_done(50);
        chk("t1_nbeats", 64'(nlog), 64'(3));
        chk_beat(0, t0 + 2, 32'h2000_0000, 4'hF, 8'h5A, 1'b0);
        chk_beat(1, t0 + 3, 32'h2000_0001, 4'hF, 8'h5B, 1'b0);
        chk_beat(2, t0 + 4, 32'h2000_0002, 4'h7, 8'h58, 1'b1);
        chk("t1_cnt", 64'(pkt_cnt), 64'(16'h0100));

        // all four ports hold a 2-beat packet
        do_reset(); t0 = cyc;
        for (int p = 0; p < N; p++) load(p, 1, 2, 32'(p) << 28);
        wait_done(100);
        chk("t2_nbeats", 64'(nlog), 64'(8));
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 2; j++)
                chk_beat(2*k + j, t0 + 2 + 3*k + j, (32'(k) << 28) | 32'(j),
                         j ? 4'h7 : 4'hF, j ? 8'h5B : 8'h5A, j != 0);
        chk("t2_prio", 64'(dut.prio_ptr), 64'(0));
        chk("t2_cnt", 64'(pkt_cnt), 64'(16'h1111));

        // five-cycle egress stall in the middle of a port-1 packet
        do_reset(); t0 = cyc;
        load(1, 1, 4, 32'h1000_0000);
        goto(t0 + 3);
        m_axis_tready = 1'b0;
        for (int c = t0 + 3; c < t0 + 8; c++) begin
            goto(c);
            #1;
            chk("bp_rdy1", 64'(s_axis_tready[1]), 64'(0));
            chk("bp_data", 64'(m_axis_tdata), 64'(32'h1000_0001));
        end
        goto(t0 + 8);
        m_axis_tready = 1'b1;
        wait_done(50);
        chk("t3_nbeats", 64'(nlog), 64'(4));
        chk_beat(0, t0 + 2,  32'h1000_0000, 4'hF, 8'h5A, 1'b0);
        chk_beat(1, t0 + 8,  32'h1000_0001, 4'hF, 8'h5B, 1'b0);
        chk_beat(2, t0 + 9,  32'h1000_0002, 4'hF, 8'h58, 1'b0);
        chk_beat(3, t0 + 10, 32'h1000_0003, 4'h7, 8'h59, 1'b1);
        chk("t3_cnt", 64'(pkt_cnt), 64'(16'h0010));

        // port 3 raises valid while port 0 is mid-packet
        do_reset(); t0 = cyc;
        load(0, 1, 4, 32'h0000_0000);
        goto(t0 + 3);
        load(3, 1, 1, 32'h3000_0000);
        for (int c = t0 + 3; c < t0 + 6; c++) begin
            goto(c);
            #1;
            chk("il_rdy3_blocked", 64'(s_axis_tready[3]), 64'(0));
        end
        goto(t0 + 6);
        #1;
        chk("il_rdy3_granted", 64'(s_axis_tready[3]), 64'(1));
        wait_done(50);
        chk("t4_nbeats", 64'(nlog), 64'(5));
        chk_beat(0, t0 + 2, 32'h0000_0000, 4'hF, 8'h5A, 1'b0);
        chk_beat(1, t0 + 3, 32'h0000_0001, 4'hF, 8'h5B, 1'b0);
        chk_beat(2, t0 + 4, 32'h0000_0002, 4'hF, 8'h58, 1'b0);
        chk_beat(3, t0 + 5, 32'h0000_0003, 4'h7, 8'h59, 1'b1);
        chk_beat(4, t0 + 7, 32'h3000_0000, 4'h7, 8'h5A, 1'b1);
        chk("t4_cnt", 64'(pkt_cnt), 64'(16'h1001));

        // 17 single-beat packets wrap a 4-bit counter to 1
        do_reset();
        load(0, 17, 1, 32'h0000_0000);
        wait_done(200);
        chk("t5_nbeats", 64'(nlog), 64'(17));
        chk("t5_cnt_wrap", 64'(pkt_cnt), 64'(16'h0001));

        // one-cycle reset during beat 2 of a 4-beat packet
        do_reset(); t0 = cyc;
        load(0, 1, 4, 32'h0500_0000);
        goto(t0 + 2);
        aresetn = 1'b0;
        clear_src();
        goto(t0 + 3);
        chk("mr_m", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast, m_axis_tvalid}, 64'(0));
        chk("mr_rdy", 64'(s_axis_tready), 64'(0));
        chk("mr_cnt", 64'(pkt_cnt), 64'(0));
        chk("mr_state", 64'(dut.state), 64'(IDLE));
        aresetn = 1'b1;
        nlog = 0;
        load(0, 1, 2, 32'h0000_0A00);
        wait_done(50);
        chk("t6_nbeats", 64'(nlog), 64'(2));
        chk_beat(0, t0 + 5, 32'h0000_0A00, 4'hF, 8'h5A, 1'b0);
        chk_beat(1, t0 + 6, 32'h0000_0A01, 4'h7, 8'h5B, 1'b1);
        chk("t6_cnt", 64'(pkt_cnt), 64'(16'h0001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
